// File: rtl/mem_bus_arbiter_if.sv
// Native-style memory bus channel (valid/ready handshake) between one master and one slave.
interface mem_bus_arbiter_if;
   logic        valid;
   logic        ready;
   logic        instr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, instr, wstrb, addr, wdata, input ready, rdata);
   modport slave  (input valid, instr, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter of the CPU (m0) and a debug/loader master (m1) onto one memory port.
// Optional feature: define ARB_TIMEOUT_EN for a BUSY watchdog that answers stalled requests with ERR_RDATA.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              resetn,
   mem_bus_arbiter_if.slave  m0,
   mem_bus_arbiter_if.slave  m1,
   mem_bus_arbiter_if.master s,
   output logic              timeout_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   state_t      next_state;
   logic        grant;
   logic        next_grant;
   logic        last_grant;
   logic        next_last_grant;
   logic        grant_valid;
   logic        timeout_hit;
   logic        respond;
   logic [31:0] resp_data;

   assign grant_valid = grant ? m1.valid : m0.valid;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] wait_count;

   assign timeout_hit = (state == BUSY) && (wait_count == TIMEOUT_LIMIT);

   // Watchdog counts stalled BUSY cycles; every return to IDLE starts it over.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wait_count  <= '0;
         timeout_err <= 1'b0;
      end
      else begin
         if (next_state == IDLE) begin
            wait_count <= '0;
         end
         else if ((state == BUSY) && !s.ready) begin
            wait_count <= wait_count + 8'd1;
         end
         if (timeout_hit && grant_valid) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end
      else begin
         state      <= next_state;
         grant      <= next_grant;
         last_grant <= next_last_grant;
      end
   end

   // Downstream fields are zeroed unless a live granted request is on the bus,
   // so an idle or losing master never leaks onto s.
   always_comb begin
      next_state      = state;
      next_grant      = grant;
      next_last_grant = last_grant;
      respond         = 1'b0;
      resp_data       = '0;
      s.valid         = 1'b0;
      s.instr         = 1'b0;
      s.wstrb         = '0;
      s.addr          = '0;
      s.wdata         = '0;
      case (state)
         IDLE: begin
            if (m0.valid && m1.valid) begin
               next_grant = !last_grant;
               next_state = BUSY;
            end
            else if (m0.valid) begin
               next_grant = 1'b0;
               next_state = BUSY;
            end
            else if (m1.valid) begin
               next_grant = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            if (!grant_valid) begin
               next_state = IDLE;
            end
            else if (timeout_hit) begin
               respond         = 1'b1;
               resp_data       = ERR_RDATA;
               next_last_grant = grant;
               next_state      = IDLE;
            end
            else begin
               s.valid = 1'b1;
               s.instr = grant ? 1'b0 : m0.instr;
               s.wstrb = grant ? m1.wstrb : m0.wstrb;
               s.addr  = grant ? m1.addr : m0.addr;
               s.wdata = grant ? m1.wdata : m0.wdata;
               if (s.ready) begin
                  respond         = 1'b1;
                  resp_data       = s.rdata;
                  next_last_grant = grant;
                  next_state      = IDLE;
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign m0.ready = respond && !grant;
   assign m1.ready = respond && grant;
   assign m0.rdata = (respond && !grant) ? resp_data : '0;
   assign m1.rdata = (respond && grant) ? resp_data : '0;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of BUSY cycles without s_ready before a timeout (8-bit range, 1..255).
REQ-002 Parameter ERR_RDATA, default 32'hDEADBEEF: read data returned on a timeout.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 m0_valid  input  1  CPU (PicoRV32 native) request.
REQ-006 m0_ready  output  1  CPU transfer complete.
REQ-007 m0_instr  input  1  CPU instruction-fetch flag.
REQ-008 m0_wstrb  input  4  CPU byte write strobes; 0 means read.
REQ-009 m0_addr  input  32  CPU byte address.
REQ-010 m0_wdata  input  32  CPU write data.
REQ-011 m0_rdata  output  32  CPU read data.
REQ-012 m1_valid  input  1  debug/loader master request.
REQ-013 m1_ready  output  1  debug master transfer complete.
REQ-014 m1_wstrb  input  4  debug master byte strobes.
REQ-015 m1_addr  input  32  debug master byte address.
REQ-016 m1_wdata  input  32  debug master write data.
REQ-017 m1_rdata  output  32  debug master read data.
REQ-018 s_valid, s_instr, s_wstrb[3:0], s_addr[31:0], s_wdata[31:0]  outputs  request toward the downstream memory controller.
REQ-019 s_ready  input  1  and s_rdata  input  32: downstream response (writes same-cycle, reads one cycle later).
REQ-020 timeout_err  output  1  sticky bus-timeout flag.

Function
REQ-021 FSM states: IDLE and BUSY; a grant register (0 = m0, 1 = m1) and a last_grant register.
REQ-022 IDLE with exactly one mX_valid high: latch grant = X and go to BUSY on the next edge; s_valid stays 0 while in IDLE.
REQ-023 IDLE with both valids high: grant = !last_grant (round-robin).
REQ-024 BUSY: s_valid = granted mX_valid; s_addr, s_wstrb and s_wdata are driven from the granted master; s_instr = m0_instr when grant = 0, else 0.
REQ-025 When a master is not granted, the downstream outputs carry no information from it; when s_valid = 0, s_wstrb = 0.
REQ-026 BUSY with s_ready = 1: drive the granted mX_ready = 1 and mX_rdata = s_rdata in the same cycle (combinational); set last_grant = grant; go to IDLE.
REQ-027 The non-granted master's ready is always 0; every mX_rdata is 0 unless its ready is 1.
REQ-028 Arbitration latency: one cycle from mX_valid to s_valid. A single IDLE cycle is required between back-to-back transactions.
REQ-029 BUSY with the granted mX_valid dropped before s_ready (protocol abort): go to IDLE with no ready pulse; last_grant is unchanged.
REQ-030 The grant never changes while in BUSY, whatever the other master does.

Reset
REQ-031 resetn = 0 asynchronously forces: state IDLE, grant 0, last_grant 1 (so the CPU wins the first contention), timeout counter 0, timeout_err 0.
REQ-032 While in reset: every output is 0 (m0_ready, m1_ready, m0_rdata, m1_rdata, all s_* outputs, timeout_err).
REQ-033 Reset asserted mid-transaction abandons the transaction with no ready pulse.

Configuration
REQ-034 Macro ARB_TIMEOUT_EN is defined: an 8-bit counter increments on each BUSY cycle with s_ready = 0 and clears on entry to IDLE.
REQ-035 When the counter reaches TIMEOUT_CYCLES:
 - granted mX_ready = 1 and mX_rdata = ERR_RDATA for one cycle;
 - s_valid = 0 in that cycle;
 - timeout_err is set and stays set until reset;
 - the FSM returns to IDLE.
REQ-036 Macro ARB_TIMEOUT_EN is undefined: no counter exists, timeout_err is tied to 0, and BUSY waits for s_ready indefinitely.

Verification
REQ-037 m0 read of addr 0x100 alone, downstream returns 0x12345678 one cycle after s_valid -> s_valid high at cycle 1, m0_ready high at cycle 2 with m0_rdata = 0x12345678, m1_ready stays 0.
REQ-038 m0 and m1 both valid from the first cycle after reset -> m0 is served first; after m0_ready, m1 is granted following one IDLE cycle; with m0 requesting again, m1 is served before m0's second transaction.
REQ-039 m1 write, wstrb 4'b0011, addr 0x7FFC, data 0xA5A5_5A5A, with same-cycle s_ready -> s_wstrb = 0011, s_addr = 0x7FFC, m1_ready high in the same cycle as s_valid.
REQ-040 Build with ARB_TIMEOUT_EN, s_ready held at 0, m0 read -> after 255 BUSY cycles m0_ready = 1 with m0_rdata = 0xDEADBEEF, timeout_err = 1 until resetn is pulsed.
REQ-041 resetn pulsed low while in BUSY -> all outputs go to 0 immediately; after release, a new m1 request is granted normally.
REQ-042 m0 drops valid in BUSY before s_ready -> FSM returns to IDLE with no m0_ready pulse, and a pending m1 request is granted next.
